note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//  Queued note scheduler that drives the sound generator's note-command inputs:
//  sound[7:0], gen[2:0] and start.
//  Accepts note commands {volume/pitch code, waveform, duration} from the CPU
//  side into a FIFO. Plays each note for its duration, counted in sampling ticks
//  (freq pulses), then emits a silence command and an inter-note gap.
//  Replaces the fixed siren pattern as the source of soundType/genType/startT.
// PARAMETERS
//  DEPTH      8    FIFO entries; power of 2, >= 2
//  DUR_W      12   duration field width in sampling ticks
//  GAP_TICKS  16   silent sampling ticks after each note; 0 = no gap
// PORTS
//  clk        in   1      system clock
//  rst        in   1      asynchronous, active-high reset
//  freq       in   1      sampling tick, 1-cycle pulse from the sample-rate divider
//  wr_valid   in   1      note write request
//  wr_ready   out  1      FIFO can accept; a write occurs when wr_valid & wr_ready
//  wr_note    in   8      {vol[1:0], octave[2:0], tone[2:0]}; octave 0 = silence
//  wr_gen     in   3      waveform: 0 sin, 1 square, 2 triangle, 3 saw, 4 noise, 5 sample
//  wr_dur     in   DUR_W  note length in freq ticks; 0 is treated as 1
//  flush      in   1      1-cycle pulse: drop queue, silence output, return to IDLE
//  sound      out  8      note code to the sound generator (soundType)
//  gen        out  3      waveform select to the sound generator (genType)
//  start      out  1      1-cycle strobe; sound/gen are valid in the same cycle
//  busy       out  1      state != IDLE or FIFO not empty
//  count      out  clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset: sound=0, gen=0, start=0, count=0, state=IDLE, all counters 0.
//    wr_ready=1 after reset unless flush is high.
//  All outputs except wr_ready are registered. wr_ready = (count < DEPTH) & ~flush.
//  FIFO:
//    - circular, pointers wrap modulo DEPTH
//    - a write and a pop in the same cycle keep count unchanged
//    - a pop decision uses the registered count, so an entry written in cycle t
//      is poppable in cycle t+1 at the earliest
//    - when full, wr_ready stays 0 in the pop cycle and rises the next cycle
//  FSM:
//    - IDLE: if count != 0, pop the head entry and go to PLAY.
//      At t+1: sound=note, gen=gen, start=1, dcnt=max(dur,1).
//    - PLAY: on each freq pulse, dcnt decrements. The pulse that makes dcnt
//      reach 0 ends the note.
//      Next cycle: sound=0, gen unchanged, start=1 (silence command).
//      Go to GAP with gcnt=GAP_TICKS, or to IDLE if GAP_TICKS=0.
//    - GAP: gcnt decrements on each freq pulse. On reaching 0, go to IDLE.
//      Queued notes are back-to-back except for the gap.
//  start is high for exactly 1 cycle per command. It is never high in
//    consecutive cycles except for flush-silence (see below).
//  freq is ignored in IDLE. freq and a state entry in the same cycle: that
//    tick is not counted.
//  sound and gen hold their last value between start strobes.
//  Flush (priority over everything):
//    - clears the FIFO and counters and goes to IDLE
//    - a write in the flush cycle is rejected (wr_ready=0)
//    - if in PLAY, the next cycle issues silence (sound=0, start=1)
//    - if in IDLE or GAP, no strobe is issued
//    - a flush in the same cycle as a pop cancels the pop's note strobe
//  Reset mid-note: outputs go to 0 immediately.
//    The downstream generator is reset by the same rst.
// TESTING
//  1. Reset, write {note=8'h4A, gen=1, dur=3}, GAP_TICKS=2
//     -> start with sound=4A, gen=1, then start with sound=00 after the 3rd freq
//        pulse, busy low 2 freq pulses later.
//  2. Fill 8 entries with wr_valid held high -> wr_ready=0 at count=8.
//     First pop -> count stays 8 for that cycle, wr_ready=1 the next cycle,
//     9th write accepted.
//  3. dur=0 -> note lasts exactly 1 freq tick. Two queued notes with GAP_TICKS=0
//     -> strobe sequence note A, silence, note B with no idle freq tick between.
//  4. Flush mid-PLAY with 3 entries queued -> next cycle sound=0, start=1,
//     count=0, state IDLE. wr_valid in the flush cycle is not accepted.
//  5. Write and pop in the same cycle at count=1 -> count stays 1, FIFO order
//     preserved (sounds A, B, C emitted in write order).
//  6. rst asserted during GAP -> sound=0, gen=0, start=0, count=0 with no clock
//     edge required.

Source files
------------

// File: rtl/note_sequencer.sv
// note_sequencer: queued note scheduler feeding the sound generator.
// Note commands {note code, waveform, duration} are queued in a circular FIFO.
// Each note plays for its duration, counted in freq ticks. A silence command
// (sound=0, start=1) follows it, then GAP_TICKS silent ticks before the next note.
//
// Ports:
//   clk, rst  system clock, asynchronous active-high reset
//   freq      sampling tick (1-cycle pulse)
//   wr_valid  note write request; accepted when wr_valid & wr_ready
//   wr_ready  FIFO can accept (combinational: not full and no flush)
//   wr_note   {vol[1:0], octave[2:0], tone[2:0]}; octave 0 = silence
//   wr_gen    waveform select
//   wr_dur    note length in freq ticks; 0 plays as 1
//   flush     drop queue, silence output, return to idle
//   sound     note code to the generator (registered)
//   gen       waveform select to the generator (registered)
//   start     1-cycle command strobe; sound/gen valid in the same cycle
//   busy      sequencer not idle or FIFO not empty (registered)
//   count     FIFO occupancy (registered)
module note_sequencer #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DUR_W     = 12,
  parameter int unsigned GAP_TICKS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freq,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [7:0]             wr_note,
  input  logic [2:0]             wr_gen,
  input  logic [DUR_W-1:0]       wr_dur,
  input  logic                   flush,
  output logic [7:0]             sound,
  output logic [2:0]             gen,
  output logic                   start,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned GapW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  state_e            state_q, state_d;
  logic [7:0]        note_mem [DEPTH];
  logic [2:0]        gen_mem  [DEPTH];
  logic [DUR_W-1:0]  dur_mem  [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [DUR_W-1:0]  dcnt_q, dcnt_d, head_dur;
  logic [GapW-1:0]   gcnt_q, gcnt_d;
  logic [7:0]        sound_q, sound_d;
  logic [2:0]        gen_q, gen_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              wr_fire, pop, note_end;

  assign wr_ready = (count_q < CntW'(DEPTH)) & ~flush;
  assign wr_fire  = wr_valid & wr_ready;
  assign head_dur = (dur_mem[rd_ptr_q] == '0) ? DUR_W'(1) : dur_mem[rd_ptr_q];
  assign note_end = (state_q == StPlay) & freq & (dcnt_q == DUR_W'(1));

  // A pop waits one cycle after any strobe so start never fires in
  // back-to-back cycles (silence followed directly by the next note).
  assign pop = (state_q == StIdle) & (count_q != '0) & ~start_q & ~flush;

  // FIFO bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(wr_fire) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      note_mem[wr_ptr_q] <= wr_note;
      gen_mem[wr_ptr_q]  <= wr_gen;
      dur_mem[wr_ptr_q]  <= wr_dur;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    gcnt_d  = gcnt_q;
    if (flush) begin
      state_d = StIdle;
      dcnt_d  = '0;
      gcnt_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pop) begin
            state_d = StPlay;
            dcnt_d  = head_dur;
          end
        end
        StPlay: begin
          if (freq) begin
            dcnt_d = dcnt_q - DUR_W'(1);
            if (note_end) begin
              if (GAP_TICKS == 0) begin
                state_d = StIdle;
              end else begin
                state_d = StGap;
                gcnt_d  = GapW'(GAP_TICKS);
              end
            end
          end
        end
        StGap: begin
          if (freq) begin
            gcnt_d = gcnt_q - GapW'(1);
            if (gcnt_q == GapW'(1)) state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output next values; sound/gen hold between strobes
  always_comb begin
    sound_d = sound_q;
    gen_d   = gen_q;
    start_d = 1'b0;
    if (flush) begin
      if (state_q == StPlay) begin
        sound_d = '0;
        start_d = 1'b1;
      end
    end else if (pop) begin
      sound_d = note_mem[rd_ptr_q];
      gen_d   = gen_mem[rd_ptr_q];
      start_d = 1'b1;
    end else if (note_end) begin
      sound_d = '0;
      start_d = 1'b1;
    end
    busy_d = (state_d != StIdle) | (count_d != '0);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dcnt_q   <= '0;
      gcnt_q   <= '0;
      sound_q  <= '0;
      gen_q    <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dcnt_q   <= dcnt_d;
      gcnt_q   <= gcnt_d;
      sound_q  <= sound_d;
      gen_q    <= gen_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
    end
  end

  assign sound = sound_q;
  assign gen   = gen_q;
  assign start = start_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: dut uses GAP_TICKS=2, dut0 uses GAP_TICKS=0.
// Both share clk/rst/freq and the write data; wr_valid and flush are separate.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freq = 1'b0;
  logic        wr_valid = 1'b0, wr_valid0 = 1'b0;
  logic        flush = 1'b0, flush0 = 1'b0;
  logic [7:0]  wr_note = '0;
  logic [2:0]  wr_gen = '0;
  logic [11:0] wr_dur = '0;
  logic        wr_ready, wr_ready0, start, start0, busy, busy0;
  logic [7:0]  sound, sound0;
  logic [2:0]  gen, gen0;
  logic [3:0]  count, count0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  note_sequencer #(.DEPTH(8), .DUR_W(12), .GAP_TICKS(2)) dut (
    .clk(clk), .rst(rst), .freq(freq), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_note(wr_note), .wr_gen(wr_gen), .wr_dur(wr_dur), .flush(flush),
    .sound(sound), .gen(gen), .start(start), .busy(busy), .count(count)
  );

  note_sequencer #(.DEPTH(8), .DUR_W(12), .GAP_TICKS(0)) dut0 (
    .clk(clk), .rst(rst), .freq(freq), .wr_valid(wr_valid0), .wr_ready(wr_ready0),
    .wr_note(wr_note), .wr_gen(wr_gen), .wr_dur(wr_dur), .flush(flush0),
    .sound(sound0), .gen(gen0), .start(start0), .busy(busy0), .count(count0)
  );

  typedef struct {
    logic       wv;
    logic [7:0] note;
    logic [2:0] g;
    logic [11:0] dur;
    logic       fr;
    logic       fl;
    logic       e_ready;
    logic       e_start;
    logic [7:0] e_sound;
    logic [2:0] e_gen;
    logic [3:0] e_count;
    logic       e_busy;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_valid = 1'b0; wr_valid0 = 1'b0; flush = 1'b0; flush0 = 1'b0; freq = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] got[3];
    int n, k;
    logic acc;

    // Test 1 table: {wv,note,gen,dur,freq,flush | ready,start,sound,gen,count,busy}
    vecs[0]  = '{1'b1, 8'h4A, 3'd1, 12'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 4'd1, 1'b1};
    vecs[1]  = '{1'b0, 8'h4A, 3'd1, 12'd3, 1'b0, 1'b0, 1'b1, 1'b1, 8'h4A, 3'd1, 4'd0, 1'b1};
    vecs[2]  = '{1'b0, 8'h4A, 3'd1, 12'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4A, 3'd1, 4'd0, 1'b1};
    vecs[3]  = '{1'b0, 8'h4A, 3'd1, 12'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h4A, 3'd1, 4'd0, 1'b1};
    vecs[4]  = '{1'b0, 8'h4A, 3'd1, 12'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h4A, 3'd1, 4'd0, 1'b1};
    vecs[5]  = '{1'b0, 8'h4A, 3'd1, 12'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h4A, 3'd1, 4'd0, 1'b1};
    vecs[6]  = '{1'b0, 8'h4A, 3'd1, 12'd3, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 3'd1, 4'd0, 1'b1};
    vecs[7]  = '{1'b0, 8'h4A, 3'd1, 12'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 4'd0, 1'b1};
    vecs[8]  = '{1'b0, 8'h4A, 3'd1, 12'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 4'd0, 1'b1};
    vecs[9]  = '{1'b0, 8'h4A, 3'd1, 12'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 4'd0, 1'b0};
    vecs[10] = '{1'b0, 8'h4A, 3'd1, 12'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 4'd0, 1'b0};

    // Reset state, checked while rst is still high
    #3;
    check("rst_sound", sound, 0);
    check("rst_gen", gen, 0);
    check("rst_start", start, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", wr_ready, 1);
    check("rst_ready0", wr_ready0, 1);
    do_reset();

    // Test 1: single note, dur 3, gap 2
    for (int i = 0; i < 11; i++) begin
      wr_valid = vecs[i].wv;
      wr_note  = vecs[i].note;
      wr_gen   = vecs[i].g;
      wr_dur   = vecs[i].dur;
      freq     = vecs[i].fr;
      flush    = vecs[i].fl;
      #1;
      check($sformatf("t1[%0d]_ready", i), wr_ready, vecs[i].e_ready);
      cyc();
      check($sformatf("t1[%0d]_start", i), start, vecs[i].e_start);
      check($sformatf("t1[%0d]_sound", i), sound, vecs[i].e_sound);
      check($sformatf("t1[%0d]_gen", i), gen, vecs[i].e_gen);
      check($sformatf("t1[%0d]_count", i), count, vecs[i].e_count);
      check($sformatf("t1[%0d]_busy", i), busy, vecs[i].e_busy);
    end
    wr_valid = 1'b0; freq = 1'b0;

    // Test 2: fill with wr_valid held high; first entry is popped on the way
    do_reset();
    wr_gen = 3'd2; wr_dur = 12'd2; wr_valid = 1'b1; wr_note = 8'h40; n = 0;
    for (int c = 0; c < 20 && wr_ready; c++) begin
      acc = wr_ready;
      cyc();
      if (acc) begin
        n++;
        wr_note = 8'(8'h40 + n);
      end
    end
    check("t2_accepted", n, 9);
    check("t2_full_count", count, 8);
    check("t2_full_ready", wr_ready, 0);
    check("t2_full_busy", busy, 1);
    freq = 1'b1; cyc();
    cyc();
    freq = 1'b0;
    check("t2_silence_start", start, 1);
    check("t2_silence_sound", sound, 0);
    cyc();
    freq = 1'b1; cyc();
    cyc();
    freq = 1'b0;
    check("t2_popcyc_count", count, 8);
    check("t2_popcyc_ready", wr_ready, 0);
    cyc();
    check("t2_pop_count", count, 7);
    check("t2_pop_start", start, 1);
    check("t2_pop_sound", sound, 8'h41);
    check("t2_after_ready", wr_ready, 1);
    cyc();
    check("t2_refill_count", count, 8);
    wr_valid = 1'b0;

    // Test 3: dur 0 and back-to-back notes with no gap (dut0)
    do_reset();
    wr_valid0 = 1'b1; wr_note = 8'h11; wr_gen = 3'd0; wr_dur = 12'd0;
    cyc();
    check("t3_count_a", count0, 1);
    wr_note = 8'h22; wr_gen = 3'd3;
    cyc();
    wr_valid0 = 1'b0;
    check("t3_a_start", start0, 1);
    check("t3_a_sound", sound0, 8'h11);
    check("t3_a_gen", gen0, 0);
    check("t3_wp_count", count0, 1);
    freq = 1'b1; cyc(); freq = 1'b0;
    check("t3_sil_start", start0, 1);
    check("t3_sil_sound", sound0, 0);
    check("t3_sil_gen", gen0, 0);
    cyc();
    check("t3_gap_start", start0, 0);
    cyc();
    check("t3_b_start", start0, 1);
    check("t3_b_sound", sound0, 8'h22);
    check("t3_b_gen", gen0, 3);
    check("t3_b_count", count0, 0);
    freq = 1'b1; cyc(); freq = 1'b0;
    check("t3_sil2_start", start0, 1);
    check("t3_sil2_sound", sound0, 0);
    check("t3_sil2_gen", gen0, 3);
    check("t3_end_busy", busy0, 0);

    // Test 4: flush mid-PLAY with 3 entries queued
    do_reset();
    wr_gen = 3'd1; wr_dur = 12'd5;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_note = 8'(8'h50 + i);
      cyc();
    end
    check("t4_queued", count, 3);
    wr_note = 8'hFF; flush = 1'b1;
    #1;
    check("t4_flush_ready", wr_ready, 0);
    cyc();
    flush = 1'b0; wr_valid = 1'b0;
    check("t4_flush_start", start, 1);
    check("t4_flush_sound", sound, 0);
    check("t4_flush_count", count, 0);
    check("t4_flush_busy", busy, 0);
    cyc();
    check("t4_post_start", start, 0);
    check("t4_post_busy", busy, 0);
    flush = 1'b1; cyc(); flush = 1'b0;
    check("t4_idle_flush_start", start, 0);
    cyc();
    check("t4_idle_count", count, 0);

    // Test 5: write+pop at count 1, order preserved (dut0)
    do_reset();
    wr_dur = 12'd1; wr_gen = 3'd4; k = 0;
    for (int c = 0; c < 80; c++) begin
      wr_valid0 = (c < 3);
      wr_note   = 8'(8'hA1 + c);
      freq      = (c >= 3) && (c % 3 == 0);
      cyc();
      if (c == 1) check("t5_wp_count", count0, 1);
      if (start0 && sound0 != 8'h00 && k < 3) begin
        got[k] = sound0;
        k++;
      end
    end
    wr_valid0 = 1'b0; freq = 1'b0;
    check("t5_notes", k, 3);
    check("t5_first", got[0], 8'hA1);
    check("t5_second", got[1], 8'hA2);
    check("t5_third", got[2], 8'hA3);

    // Test 6: asynchronous reset during GAP, then during PLAY
    do_reset();
    wr_valid = 1'b1; wr_note = 8'h4A; wr_gen = 3'd1; wr_dur = 12'd1;
    cyc();
    wr_note = 8'h5B;
    cyc();
    wr_valid = 1'b0;
    freq = 1'b1; cyc(); freq = 1'b0;
    cyc();
    check("t6_pre_count", count, 1);
    check("t6_pre_gen", gen, 1);
    check("t6_pre_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("t6_gap_sound", sound, 0);
    check("t6_gap_gen", gen, 0);
    check("t6_gap_start", start, 0);
    check("t6_gap_count", count, 0);
    check("t6_gap_busy", busy, 0);
    cyc();
    rst = 1'b0;
    wr_valid = 1'b1; wr_note = 8'h6C; wr_dur = 12'd4;
    cyc();
    wr_valid = 1'b0;
    cyc();
    cyc();
    check("t6_play_sound_pre", sound, 8'h6C);
    #2 rst = 1'b1;
    #1;
    check("t6_play_sound", sound, 0);
    check("t6_play_gen", gen, 0);
    cyc();
    rst = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
